if_prefetch: RTL and testbench
==============================

Name: if_prefetch

Overview:
Instruction-fetch front end sitting directly upstream of the FD stage register.
- Owns the fetch PC and issues word reads to instruction memory over a req/ack handshake.
- Buffers returned instructions, each with its next-PC (pc+4), in a small FIFO.
- Presents the FIFO head to the FD stage. A redirect from the MW stage (branch/jump target) flushes the FIFO and discards any in-flight fetch.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock
reset  in  1  reset; synchronous, active-high
mem_req  out  1  fetch request to instruction memory
mem_addr  out  32  fetch word address; bits [1:0] always 0
mem_ack  in  1  request accepted; mem_rdata valid this cycle
mem_rdata  in  32  fetched instruction
redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc
redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0)
ins_valid  out  1  FIFO head valid
ins  out  32  head instruction; 0 when ins_valid=0
ins_next_pc  out  32  head pc+4; 0 when ins_valid=0
ins_ready  in  1  FD stage consumes head this cycle (FD wren)

Behaviour:
- Reset values: mem_req=0, mem_addr=RESET_PC, ins_valid=0, ins=0, ins_next_pc=0, FIFO count=0, fetch_pc=RESET_PC, state=IDLE.
- A reset asserted mid-operation overrides everything, including an outstanding request. The memory side must tolerate a dropped request.
- Only one fetch may be outstanding. mem_addr equals fetch_pc whenever mem_req=1.
- FSM states:
  - IDLE: mem_req=0. Go to REQ when count<DEPTH.
  - REQ: mem_req=1, held with stable mem_addr until mem_ack.
    - On ack: push {mem_rdata, fetch_pc+4}, fetch_pc+=4.
    - Then go to REQ if count after push/pop <DEPTH, else IDLE.
  - DISCARD: mem_req=1 at the stale address; a request is never withdrawn. On ack, drop the data, then go to REQ.
- Redirect:
  - Any state: FIFO flushed (count=0) and fetch_pc=redirect_pc&~3, effective next cycle.
  - In REQ without ack: go to DISCARD.
  - In REQ with ack in the same cycle: ack data dropped; go to REQ.
  - In IDLE or DISCARD: go to REQ (DISCARD remains if its ack is still pending).
  - Redirect has priority over push and pop in the same cycle. ins_valid=0 the following cycle.
- Latency:
  - An ack at cycle N gives ins_valid=1 with that data at cycle N+1 (registered push; no bypass).
  - After reset deasserts, mem_req rises on the next cycle.
- Handshake: the head is consumed when ins_valid&ins_ready. ins_ready while empty has no effect.
- Full/empty:
  - No request is issued while count=DEPTH.
  - Simultaneous push and pop leaves count unchanged, and no overflow is possible.
  - Pop from empty is ignored.
- Arithmetic: 32-bit modulo; fetch_pc 32'hFFFF_FFFC+4 wraps to 0. ins_next_pc wraps identically.

Optional Feature:
IF_PREFETCH_STATS_EN
- Defined: adds outputs stat_fetch_cnt (32) and stat_discard_cnt (32).
  - stat_fetch_cnt increments on every pushed ack.
  - stat_discard_cnt increments on every dropped ack (DISCARD, or redirect coincident with ack).
  - Both clear on reset and wrap modulo 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared package kanade32_pkg holds:
  - the fetch FSM state encoding (IDLE, REQ, DISCARD);
  - RESET_PC default;
  - the INS_WIDTH=32 and ADDR_WIDTH=32 constants;
  - the FIFO entry typedef {ins, next_pc}.
- One sub-module, if_fifo: synchronous FIFO with push, pop, flush, count, full and empty.

Test Plan:
- Reset release with mem_ack always 1 and mem_rdata=addr^32'hA5A5_0000 -> mem_addr sequence 0,4,8,...; first ins_valid one cycle after first ack; ins_next_pc=4,8,...
- ins_ready=0, acks always granted -> exactly DEPTH pushes (count=4), then mem_req=0; one ins_ready pulse -> one further request issued.
- Redirect to 32'h0000_0103 while a request to 0x10 is pending without ack -> FIFO empty next cycle; ack at 0x10 dropped; next request at 0x100.
- Redirect coincident with mem_ack and ins_ready -> ack data not pushed, no pop effect, next mem_addr=redirect target, ins_valid=0.
- Redirect to 32'hFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0; ins_next_pc values 0x0 then 0x4.
- Reset asserted during DISCARD -> mem_req=0, fetch_pc=RESET_PC; with IF_PREFETCH_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/kanade32_pkg.sv
// Shared definitions for the kanade32 instruction-fetch front end.
// Contents: fetch FSM state encoding, reset PC default, datapath widths,
// and the prefetch FIFO entry type {ins, next_pc}.
package kanade32_pkg;

    localparam int INS_WIDTH  = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_t;

    // One buffered instruction together with the PC of the following word
    typedef struct packed {
        logic [INS_WIDTH-1:0]  ins;
        logic [ADDR_WIDTH-1:0] next_pc;
    } fifo_entry_t;

    // Word-align an address by clearing the two byte-offset bits
    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fifo.sv
// Synchronous FIFO buffering fetched instructions for the prefetch unit.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_push/i_data   write an entry (ignored when full)
//   i_pop           remove the head entry (ignored when empty)
//   i_flush         empty the FIFO; overrides push and pop
//   o_head          head entry (raw storage, caller masks when empty)
//   o_count         number of valid entries (0..DEPTH)
//   o_full/o_empty  status flags derived from o_count
module if_fifo
    import kanade32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  fifo_entry_t              i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output fifo_entry_t              o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fifo_entry_t     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == {CW{1'b0}});
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full & ~i_flush;
    assign w_pop_ok  = i_pop & ~o_empty & ~i_flush;

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents beyond the valid window are don't-care, so no reset
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end feeding the FD stage register.
// Owns the fetch PC, issues one outstanding word read at a time over a
// req/ack handshake, buffers returned words with their pc+4 in if_fifo, and
// presents the FIFO head to FD. A redirect flushes the buffer and refetches;
// a request already on the bus is completed in DISCARD and its data dropped.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mem_req, mem_addr          fetch request and word address (registered)
//   mem_ack, mem_rdata         request accepted, data valid in the same cycle
//   redirect, redirect_pc      one-cycle flush/refetch pulse and new PC
//   ins_valid, ins, ins_next_pc  FIFO head towards FD (zero when empty)
//   ins_ready                  FD consumes the head this cycle
// Optional build macro IF_PREFETCH_STATS_EN adds stat_fetch_cnt and
// stat_discard_cnt (pushed acks and dropped acks respectively).
module if_prefetch
    import kanade32_pkg::*;
#(
    parameter int                    DEPTH    = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [INS_WIDTH-1:0]  mem_rdata,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  ins_valid,
    output logic [INS_WIDTH-1:0]  ins,
    output logic [ADDR_WIDTH-1:0] ins_next_pc,
    input  logic                  ins_ready
`ifdef IF_PREFETCH_STATS_EN
    ,
    output logic [31:0]           stat_fetch_cnt,
    output logic [31:0]           stat_discard_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t          r_state;
    fetch_state_t          w_state_next;
    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_next;
    logic [ADDR_WIDTH-1:0] w_fetch_pc_inc;
    logic                  r_mem_req;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic                  w_ack;
    logic                  w_push;
    logic                  w_drop;
    logic                  w_pop;
    fifo_entry_t           w_push_data;
    fifo_entry_t           w_head;
    logic [CW-1:0]         w_count;
    logic [CW-1:0]         w_count_after_push;
    logic                  w_full;
    logic                  w_empty;

    // An ack is only meaningful while a request is actually on the bus
    assign w_ack          = mem_ack & r_mem_req;
    assign w_fetch_pc_inc = r_fetch_pc + 32'd4;
    // Redirect wins over pop, so a coincident ins_ready does not consume anything
    assign w_pop          = ins_ready & ~w_empty & ~redirect;
    assign w_count_after_push = w_count + CW'(1) - CW'(w_pop);

    assign w_push_data.ins     = mem_rdata;
    assign w_push_data.next_pc = w_fetch_pc_inc;

    if_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Next-state, next fetch PC and push/drop decisions
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_push          = 1'b0;
        w_drop          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_next = word_align(redirect_pc);
                    w_state_next    = ST_REQ;
                end else if (!w_full) begin
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    w_fetch_pc_next = word_align(redirect_pc);
                    if (w_ack) begin
                        w_drop       = 1'b1;
                        w_state_next = ST_REQ;
                    end else begin
                        // Request cannot be withdrawn: finish it and drop the data
                        w_state_next = ST_DISCARD;
                    end
                end else if (w_ack) begin
                    w_push          = 1'b1;
                    w_fetch_pc_next = w_fetch_pc_inc;
                    if (w_count_after_push < CW'(DEPTH)) begin
                        w_state_next = ST_REQ;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_REQ;
                end
            end
            ST_DISCARD: begin
                if (redirect) begin
                    w_fetch_pc_next = word_align(redirect_pc);
                end else begin
                    w_fetch_pc_next = r_fetch_pc;
                end
                if (w_ack) begin
                    w_drop       = 1'b1;
                    w_state_next = ST_REQ;
                end else begin
                    w_state_next = ST_DISCARD;
                end
            end
            default: begin
                w_state_next    = ST_IDLE;
                w_fetch_pc_next = r_fetch_pc;
            end
        endcase
    end

    // State, fetch PC and registered memory request; DISCARD keeps the stale address
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            r_mem_req  <= (w_state_next != ST_IDLE);
            if (w_state_next == ST_DISCARD) begin
                r_mem_addr <= r_mem_addr;
            end else begin
                r_mem_addr <= w_fetch_pc_next;
            end
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign ins_valid   = ~w_empty;
    assign ins         = w_empty ? 32'h0000_0000 : w_head.ins;
    assign ins_next_pc = w_empty ? 32'h0000_0000 : w_head.next_pc;

`ifdef IF_PREFETCH_STATS_EN
    logic [31:0] r_stat_fetch_cnt;
    logic [31:0] r_stat_discard_cnt;

    // Pushed and dropped ack counters, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_fetch_cnt   <= 32'd0;
            r_stat_discard_cnt <= 32'd0;
        end else begin
            if (w_push) begin
                r_stat_fetch_cnt <= r_stat_fetch_cnt + 32'd1;
            end
            if (w_drop) begin
                r_stat_discard_cnt <= r_stat_discard_cnt + 32'd1;
            end
        end
    end

    assign stat_fetch_cnt   = r_stat_fetch_cnt;
    assign stat_discard_cnt = r_stat_discard_cnt;
`endif

endmodule

// File: tb/tb_if_prefetch.sv
// Directed self-checking bench for if_prefetch. Memory returns addr^A5A5_0000.
module tb_if_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ins_valid;
    logic [31:0] ins;
    logic [31:0] ins_next_pc;
    logic        ins_ready;
`ifdef IF_PREFETCH_STATS_EN
    logic [31:0] stat_fetch_cnt;
    logic [31:0] stat_discard_cnt;
`endif

    int checks = 0;
    int errors = 0;

    assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

    always #5 clk = ~clk;

    if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ins_valid   (ins_valid),
        .ins         (ins),
        .ins_next_pc (ins_next_pc),
        .ins_ready   (ins_ready)
`ifdef IF_PREFETCH_STATS_EN
        ,
        .stat_fetch_cnt   (stat_fetch_cnt),
        .stat_discard_cnt (stat_discard_cnt)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic ack, input logic ready);
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; mem_ack = ack; ins_ready = ready;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; mem_ack = 1'b1; ins_ready = 1'b0;
        step(); step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_ins_valid: got %b expected 0", ins_valid); end
        checks++; if (ins !== 32'h0) begin errors++; $display("FAIL reset_ins: got %h expected 0", ins); end
        checks++; if (ins_next_pc !== 32'h0) begin errors++; $display("FAIL reset_next_pc: got %h expected 0", ins_next_pc); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_ins;
        logic [31:0] exp_pc;
        do_reset(1'b1, 1'b1);
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL stream_first_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_addr: got %h expected 0", mem_addr); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL stream_valid_before_ack: got %b expected 0", ins_valid); end
        for (int k = 1; k <= 4; k++) begin
            step();
            exp_pc  = 32'(4 * k);
            exp_ins = 32'(4 * (k - 1)) ^ 32'hA5A5_0000;
            checks++; if (mem_addr !== exp_pc) begin errors++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, mem_addr, exp_pc); end
            checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, ins_valid); end
            checks++; if (ins !== exp_ins) begin errors++; $display("FAIL stream_ins[%0d]: got %h expected %h", k, ins, exp_ins); end
            checks++; if (ins_next_pc !== exp_pc) begin errors++; $display("FAIL stream_next_pc[%0d]: got %h expected %h", k, ins_next_pc, exp_pc); end
        end
    endtask

    task automatic test_full();
        do_reset(1'b1, 1'b0);
        step();
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL full_first_addr: got %h expected 0", mem_addr); end
        step(); step(); step(); step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_req_stops: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL full_idle_addr: got %h expected 10", mem_addr); end
        checks++; if (ins !== 32'hA5A5_0000) begin errors++; $display("FAIL full_head_ins: got %h expected a5a50000", ins); end
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_req_stays_low: got %b expected 0", mem_req); end
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0;
        checks++; if (ins !== 32'hA5A5_0004) begin errors++; $display("FAIL full_pop_ins: got %h expected a5a50004", ins); end
        checks++; if (ins_next_pc !== 32'h8) begin errors++; $display("FAIL full_pop_next_pc: got %h expected 8", ins_next_pc); end
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL full_refill_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL full_refill_addr: got %h expected 10", mem_addr); end
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_single_refill: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h14) begin errors++; $display("FAIL full_after_refill_addr: got %h expected 14", mem_addr); end
    endtask

    task automatic test_redirect_pending();
        do_reset(1'b1, 1'b1);
        step(); step(); step(); step(); step();
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL rp_addr_before: got %h expected 10", mem_addr); end
        mem_ack = 1'b0; ins_ready = 1'b0;
        step();
        checks++; if (ins !== 32'hA5A5_000C) begin errors++; $display("FAIL rp_head_before: got %h expected a5a5000c", ins); end
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        step();
        redirect = 1'b0;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rp_flush_valid: got %b expected 0", ins_valid); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rp_req_held: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL rp_stale_addr: got %h expected 10", mem_addr); end
        step();
        checks++; if (mem_addr !== 32'h10) begin errors++; $display("FAIL rp_stale_addr_hold: got %h expected 10", mem_addr); end
        mem_ack = 1'b1;
        step();
        checks++; if (mem_addr !== 32'h100) begin errors++; $display("FAIL rp_new_addr: got %h expected 100", mem_addr); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rp_drop_valid: got %b expected 0", ins_valid); end
        step();
        checks++; if (ins !== 32'hA5A5_0100) begin errors++; $display("FAIL rp_target_ins: got %h expected a5a50100", ins); end
        checks++; if (ins_next_pc !== 32'h104) begin errors++; $display("FAIL rp_target_next_pc: got %h expected 104", ins_next_pc); end
    endtask

    task automatic test_redirect_ack();
        do_reset(1'b1, 1'b0);
        step(); step(); step();
        redirect = 1'b1; redirect_pc = 32'h0000_0200; ins_ready = 1'b1;
        step();
        redirect = 1'b0; ins_ready = 1'b0;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL ra_valid: got %b expected 0", ins_valid); end
        checks++; if (ins !== 32'h0) begin errors++; $display("FAIL ra_ins_zero: got %h expected 0", ins); end
        checks++; if (ins_next_pc !== 32'h0) begin errors++; $display("FAIL ra_next_pc_zero: got %h expected 0", ins_next_pc); end
        checks++; if (mem_addr !== 32'h200) begin errors++; $display("FAIL ra_addr: got %h expected 200", mem_addr); end
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ra_req: got %b expected 1", mem_req); end
        step();
        checks++; if (ins !== 32'hA5A5_0200) begin errors++; $display("FAIL ra_target_ins: got %h expected a5a50200", ins); end
        checks++; if (ins_next_pc !== 32'h204) begin errors++; $display("FAIL ra_target_next_pc: got %h expected 204", ins_next_pc); end
`ifdef IF_PREFETCH_STATS_EN
        checks++; if (stat_fetch_cnt !== 32'd3) begin errors++; $display("FAIL ra_stat_fetch: got %0d expected 3", stat_fetch_cnt); end
        checks++; if (stat_discard_cnt !== 32'd1) begin errors++; $display("FAIL ra_stat_discard: got %0d expected 1", stat_discard_cnt); end
`endif
    endtask

    task automatic test_wrap();
        do_reset(1'b0, 1'b0);
        step();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        step();
        redirect = 1'b0;
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_stale_addr: got %h expected 0", mem_addr); end
        mem_ack = 1'b1;
        step();
        checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr_top: got %h expected fffffffc", mem_addr); end
        ins_ready = 1'b1;
        step();
        checks++; if (ins !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_ins_top: got %h expected 5a5afffc", ins); end
        checks++; if (ins_next_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc_top: got %h expected 0", ins_next_pc); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr_zero: got %h expected 0", mem_addr); end
        step();
        ins_ready = 1'b0;
        checks++; if (ins !== 32'hA5A5_0000) begin errors++; $display("FAIL wrap_ins_zero: got %h expected a5a50000", ins); end
        checks++; if (ins_next_pc !== 32'h4) begin errors++; $display("FAIL wrap_next_pc_zero: got %h expected 4", ins_next_pc); end
    endtask

    task automatic test_reset_discard();
        do_reset(1'b0, 1'b1);
        step();
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rd_ready_while_empty: got %b expected 0", ins_valid); end
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect = 1'b0; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0080;
        step();
        redirect = 1'b0;
        checks++; if (mem_addr !== 32'h40) begin errors++; $display("FAIL rd_discard_addr: got %h expected 40", mem_addr); end
`ifdef IF_PREFETCH_STATS_EN
        checks++; if (stat_discard_cnt !== 32'd1) begin errors++; $display("FAIL rd_stat_discard_pre: got %0d expected 1", stat_discard_cnt); end
`endif
        reset = 1'b1;
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rd_reset_req: got %b expected 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rd_reset_addr: got %h expected 0", mem_addr); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rd_reset_valid: got %b expected 0", ins_valid); end
`ifdef IF_PREFETCH_STATS_EN
        checks++; if (stat_fetch_cnt !== 32'd0) begin errors++; $display("FAIL rd_stat_fetch_clr: got %0d expected 0", stat_fetch_cnt); end
        checks++; if (stat_discard_cnt !== 32'd0) begin errors++; $display("FAIL rd_stat_discard_clr: got %0d expected 0", stat_discard_cnt); end
`endif
        reset = 1'b0;
        step();
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rd_restart_req: got %b expected 1", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL rd_restart_addr: got %h expected 0", mem_addr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_redirect_pending();
        test_redirect_ack();
        test_wrap();
        test_reset_discard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
